// File: rtl/cp0_reg.sv
// CP0 coprocessor register block: Count/Compare timer, Status, Cause, EPC, PrId, Config.
// Optional compare-match timer interrupt is built when CP0_TIMER_EN is defined.
module cp0_reg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wen,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [31:0] o_rdata,
  input  logic [5:0]  i_int,
  input  logic [31:0] i_excepttype,
  input  logic [31:0] i_current_inst_addr,
  input  logic        i_is_in_delayslot,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc,
  output logic [31:0] o_config,
  output logic [31:0] o_prid,
  output logic        o_timer_int
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
  localparam logic [31:0] PRID_VAL    = 32'h004C_0102;
  // Software-writable Cause fields: IV, WP, IP[1:0]
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  logic [31:0] status_d;
  logic [31:0] cause_d;
  logic [31:0] epc_d;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  logic        exc_take;
  logic        eret;
  logic [4:0]  exc_code;
  logic        exl;

  assign wr_count   = i_wen && (i_waddr == REG_COUNT);
  assign wr_compare = i_wen && (i_waddr == REG_COMPARE);
  assign wr_status  = i_wen && (i_waddr == REG_STATUS);
  assign wr_cause   = i_wen && (i_waddr == REG_CAUSE);
  assign wr_epc     = i_wen && (i_waddr == REG_EPC);

  assign exl  = status_q[1];
  assign eret = (i_excepttype == EXC_ERET);

  always_comb begin
    exc_take = 1'b1;
    exc_code = 5'd0;
    case (i_excepttype)
      EXC_INT:  exc_code = 5'd0;
      EXC_SYS:  exc_code = 5'd8;
      EXC_RI:   exc_code = 5'd10;
      EXC_OV:   exc_code = 5'd12;
      EXC_TRAP: exc_code = 5'd13;
      default:  exc_take = 1'b0;
    endcase
  end

  // Writes form the base value; exception/eret fields are then overlaid so they win.
  always_comb begin
    status_d = wr_status ? i_wdata : status_q;
    if (exc_take) begin
      status_d[1] = 1'b1;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end

    cause_d = cause_q;
    if (wr_cause) begin
      cause_d = (cause_q & ~CAUSE_WMASK) | (i_wdata & CAUSE_WMASK);
    end
    cause_d[15:10] = i_int;

    epc_d = wr_epc ? i_wdata : epc_q;

    if (exc_take) begin
      cause_d[6:2] = exc_code;
      if (!exl) begin
        cause_d[31] = i_is_in_delayslot;
        epc_d       = i_is_in_delayslot ? (i_current_inst_addr - 32'd4)
                                        : i_current_inst_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= i_wdata;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      compare_q <= '0;
    end else if (wr_compare) begin
      compare_q <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

`ifdef CP0_TIMER_EN
  logic timer_q;

  // Sticky until software rewrites Compare; a same-cycle Compare write beats a match.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_q <= 1'b0;
    end else if (wr_compare) begin
      timer_q <= 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_q <= 1'b1;
    end
  end

  assign o_timer_int = timer_q;
`else
  assign o_timer_int = 1'b0;
`endif

  always_comb begin
    o_rdata = 32'd0;
    case (i_raddr)
      REG_COUNT:   o_rdata = count_q;
      REG_COMPARE: o_rdata = compare_q;
      REG_STATUS:  o_rdata = status_q;
      REG_CAUSE:   o_rdata = cause_q;
      REG_EPC:     o_rdata = epc_q;
      REG_PRID:    o_rdata = PRID_VAL;
      REG_CONFIG:  o_rdata = CONFIG_VAL;
      default:     o_rdata = 32'd0;
    endcase
  end

  assign o_count   = count_q;
  assign o_compare = compare_q;
  assign o_status  = status_q;
  assign o_cause   = cause_q;
  assign o_epc     = epc_q;
  assign o_config  = CONFIG_VAL;
  assign o_prid    = PRID_VAL;

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: stimulus pushes model expectations, monitor pops and compares.
// Honours CP0_TIMER_EN the same way the design does.
module tb_cp0_reg;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [31:0] PRID   = 32'h004C_0102;
  localparam logic [31:0] CONFIG = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_wen = 1'b0;
  logic [4:0]  i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic [4:0]  i_raddr = '0;
  logic [31:0] o_rdata;
  logic [5:0]  i_int = '0;
  logic [31:0] i_excepttype = '0;
  logic [31:0] i_current_inst_addr = '0;
  logic        i_is_in_delayslot = 1'b0;
  logic [31:0] o_count, o_compare, o_status, o_cause, o_epc, o_config, o_prid;
  logic        o_timer_int;

  always #5 clk = ~clk;

  cp0_reg dut (
    .i_clk(clk), .i_rst(i_rst), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_raddr(i_raddr), .o_rdata(o_rdata), .i_int(i_int), .i_excepttype(i_excepttype),
    .i_current_inst_addr(i_current_inst_addr), .i_is_in_delayslot(i_is_in_delayslot),
    .o_count(o_count), .o_compare(o_compare), .o_status(o_status), .o_cause(o_cause),
    .o_epc(o_epc), .o_config(o_config), .o_prid(o_prid), .o_timer_int(o_timer_int)
  );

  typedef struct {
    logic [31:0] count, compare, status, cause, epc, rdata;
    logic        timer;
    logic [4:0]  dmask;
    logic [31:0] dcount, dstatus, dcause, depc;
    logic        dtimer;
  } item_t;

  item_t q[$];
  int checks = 0;
  int failures = 0;

  // reference state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  // directed expectations attached to the next step (bit0 count,1 status,2 cause,3 epc,4 timer)
  logic [4:0]  d_mask = '0;
  logic [31:0] d_count, d_status, d_cause, d_epc;
  logic        d_timer;
  logic [4:0]  cur_raddr = 5'd16;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
      5'd16: return CONFIG;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exc_code_of(input logic [31:0] et);
    case (et)
      32'h1: return 0;
      32'h8: return 8;
      32'ha: return 10;
      32'hc: return 12;
      32'hd: return 13;
      default: return -1;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic wen, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [5:0] intr,
                            input logic [31:0] et, input logic [31:0] pc, input logic ds);
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_timer;
    int code;
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
      m_cause = 0; m_epc = 0; m_timer = 0;
      return;
    end
    n_count   = (wen && wa == 9)  ? wd : m_count + 1;
    n_compare = (wen && wa == 11) ? wd : m_compare;
    n_status  = (wen && wa == 12) ? wd : m_status;
    n_epc     = (wen && wa == 14) ? wd : m_epc;
    n_cause   = (wen && wa == 13) ? ((m_cause & ~32'h00C0_0300) | (wd & 32'h00C0_0300)) : m_cause;
    n_cause   = (n_cause & ~32'h0000_FC00) | (32'(intr) * 32'd1024);
    code = exc_code_of(et);
    if (code >= 0) begin
      if ((m_status & 32'h2) == 0) begin
        n_epc   = ds ? pc - 4 : pc;
        n_cause = ds ? (n_cause | 32'h8000_0000) : (n_cause & 32'h7FFF_FFFF);
      end
      n_status = n_status | 32'h2;
      n_cause  = (n_cause & ~32'h7C) | (32'(code) * 32'd4);
    end else if (et == 32'he) begin
      n_status = n_status & ~32'h2;
    end
    if (!TIMER_EN)                              n_timer = 0;
    else if (wen && wa == 11)                   n_timer = 0;
    else if (m_compare != 0 && m_count == m_compare) n_timer = 1;
    else                                        n_timer = m_timer;
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
  endtask

  task automatic step(input logic rst, input logic wen, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [5:0] intr,
                      input logic [31:0] et, input logic [31:0] pc, input logic ds);
    item_t it;
    @(negedge clk);
    i_rst = rst; i_wen = wen; i_waddr = wa; i_wdata = wd; i_int = intr;
    i_excepttype = et; i_current_inst_addr = pc; i_is_in_delayslot = ds;
    i_raddr = cur_raddr;
    model_step(rst, wen, wa, wd, intr, et, pc, ds);
    it.count = m_count; it.compare = m_compare; it.status = m_status;
    it.cause = m_cause; it.epc = m_epc; it.timer = m_timer;
    it.rdata = model_read(cur_raddr);
    it.dmask = d_mask; it.dcount = d_count; it.dstatus = d_status;
    it.dcause = d_cause; it.depc = d_epc; it.dtimer = d_timer;
    q.push_back(it);
    d_mask = '0;
  endtask

  task automatic idle(input logic [5:0] intr);
    step(1'b0, 1'b0, 5'd0, 32'd0, intr, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 1'b1, wa, wd, 6'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every clock edge presents a new register image
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("count",   o_count,   it.count);
        chk("compare", o_compare, it.compare);
        chk("status",  o_status,  it.status);
        chk("cause",   o_cause,   it.cause);
        chk("epc",     o_epc,     it.epc);
        chk("config",  o_config,  CONFIG);
        chk("prid",    o_prid,    PRID);
        chk("timer",   32'(o_timer_int), 32'(it.timer));
        chk("rdata",   o_rdata,   it.rdata);
        if (it.dmask[0]) chk("dir_count",  o_count,  it.dcount);
        if (it.dmask[1]) chk("dir_status", o_status, it.dstatus);
        if (it.dmask[2]) chk("dir_cause",  o_cause,  it.dcause);
        if (it.dmask[3]) chk("dir_epc",    o_epc,    it.depc);
        if (it.dmask[4]) chk("dir_timer",  32'(o_timer_int), 32'(it.dtimer));
      end
    end
  end

  initial begin
    logic [4:0]  wa;
    logic [31:0] wd, et;
    int sel;
    logic [4:0]  addr_pool [8];
    logic [31:0] et_pool [10];
    addr_pool = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};
    et_pool   = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h0};

    // reset then five idle cycles
    step(1'b1, 1'b0, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 6'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        d_mask = 5'b00011; d_count = 32'd5; d_status = 32'h1000_0000;
      end
      idle(6'd0);
    end

    // Count wrap
    cur_raddr = 5'd9;
    d_mask = 5'b00001; d_count = 32'hFFFF_FFFE; wr(5'd9, 32'hFFFF_FFFE);
    d_mask = 5'b00001; d_count = 32'hFFFF_FFFF; idle(6'd0);
    d_mask = 5'b00001; d_count = 32'h0000_0000; idle(6'd0);

    // Cause write masking and IP capture
    cur_raddr = 5'd13;
    d_mask = 5'b00100; d_cause = 32'h00C0_AB00;
    step(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 6'b101010, 32'd0, 32'd0, 1'b0);

    // compare-match timer
    cur_raddr = 5'd11;
    wr(5'd11, 32'h20);
    wr(5'd9, 32'h1C);
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) begin
        d_mask = 5'b10000; d_timer = TIMER_EN;
      end
      idle(6'd0);
    end
    d_mask = 5'b10000; d_timer = 1'b0; wr(5'd11, 32'h40);
    wr(5'd9, 32'h40);
    d_mask = 5'b10000; d_timer = 1'b0; wr(5'd11, 32'h40);
    d_mask = 5'b10000; d_timer = 1'b0; idle(6'd0);

    // exception entry in delay slot, then eret
    cur_raddr = 5'd14;
    wr(5'd12, 32'h0);
    d_mask = 5'b01110; d_epc = 32'hFC; d_status = 32'h2; d_cause = 32'h80C0_0320;
    step(1'b0, 1'b0, 5'd0, 32'd0, 6'd0, 32'h8, 32'h100, 1'b1);
    d_mask = 5'b01010; d_epc = 32'hFC; d_status = 32'h0;
    step(1'b0, 1'b0, 5'd0, 32'd0, 6'd0, 32'he, 32'h500, 1'b0);

    // write/exception collision, then same again under reset
    cur_raddr = 5'd12;
    d_mask = 5'b01010; d_status = 32'h2; d_epc = 32'h300;
    step(1'b0, 1'b1, 5'd12, 32'h0, 6'd0, 32'h1, 32'h300, 1'b0);
    d_mask = 5'b11111; d_status = 32'h1000_0000; d_count = 0; d_cause = 0; d_epc = 0; d_timer = 0;
    step(1'b1, 1'b1, 5'd12, 32'h0, 6'd0, 32'h1, 32'h300, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cur_raddr = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 7);
      wa  = (sel == 7) ? 5'($urandom_range(0, 31)) : addr_pool[sel];
      wd  = $urandom;
      if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = m_count + 32'($urandom_range(1, 6));
      if (wa == 5'd9 && $urandom_range(0, 3) == 0) wd = m_compare - 32'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      et  = (sel == 9) ? $urandom : et_pool[sel];
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3), wa, wd,
           6'($urandom_range(0, 63)), et, $urandom, 1'($urandom_range(0, 1)));
    end

    idle(6'd0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
